// File: rtl/lane_shift_pkg.sv
// Shared definitions for the lane shifter: shift modes, shift-width helper,
// and the width of the optional error counter.
package lane_shift_pkg;

  typedef enum logic [1:0] {
    SHL_FILL = 2'b00,
    SHR_FILL = 2'b01,
    ROTL     = 2'b10,
    ROTR     = 2'b11
  } shift_mode_e;

  localparam int unsigned ERR_CNT_W = 16;

  // Width of a shift amount able to address every lane.
  function automatic int unsigned shift_w(input int unsigned lanes);
    return $clog2(lanes);
  endfunction

endpackage

// File: rtl/lane_shift_core.sv
// Combinational lane shifter: log2(LANES)-level mux tree, one level per
// shift-amount bit. Fill lanes shifted in by an early level remain fill
// in later levels, so composing per-bit shifts gives the full fill shift.
// Shift amounts above MAX_SHIFT return an all-fill word with err set.
module lane_shift_core
  import lane_shift_pkg::*;
#(
  parameter int unsigned LANE_W    = 12,
  parameter int unsigned LANES     = 8,
  parameter int unsigned MAX_SHIFT = 5
) (
  input  logic [LANES*LANE_W-1:0]    data,
  input  logic [shift_w(LANES)-1:0]  shift,
  input  logic [1:0]                 mode,
  input  logic [LANE_W-1:0]          fill,
  output logic [LANES*LANE_W-1:0]    result,
  output logic                       err
);

  localparam int unsigned SW = shift_w(LANES);
  localparam int unsigned W  = LANES * LANE_W;
  localparam logic [SW-1:0] MAX_S = SW'(MAX_SHIFT);

  logic go_right;
  logic wrap;

  assign go_right = (mode == SHR_FILL) || (mode == ROTR);
  assign wrap     = (mode == ROTL)     || (mode == ROTR);

  genvar l, k;
  for (l = 0; l < SW; l++) begin : g_lvl
    localparam int unsigned D = 1 << l;
    logic [W-1:0] d_in;
    logic [W-1:0] q;

    if (l == 0) begin : g_src_first
      assign d_in = data;
    end else begin : g_src_next
      assign d_in = g_lvl[l-1].q;
    end

    for (k = 0; k < LANES; k++) begin : g_lane
      logic [LANE_W-1:0] from_lo;
      logic [LANE_W-1:0] from_hi;

      if (k >= D) begin : g_lo_in
        assign from_lo = d_in[(k-D)*LANE_W +: LANE_W];
      end else begin : g_lo_edge
        assign from_lo = wrap ? d_in[(k+LANES-D)*LANE_W +: LANE_W] : fill;
      end

      if (k + D < LANES) begin : g_hi_in
        assign from_hi = d_in[(k+D)*LANE_W +: LANE_W];
      end else begin : g_hi_edge
        assign from_hi = wrap ? d_in[(k+D-LANES)*LANE_W +: LANE_W] : fill;
      end

      assign q[k*LANE_W +: LANE_W] = !shift[l] ? d_in[k*LANE_W +: LANE_W]
                                   : (go_right ? from_hi : from_lo);
    end
  end

  assign err    = (shift > MAX_S);
  assign result = err ? {LANES{fill}} : g_lvl[SW-1].q;

endmodule

// File: rtl/lane_shifter_pipe.sv
// Two-stage valid/ready pipelined lane shifter. S1 registers the shifter
// result; S2 is the output register that drives out_* directly.
// Optional error counter (err_cnt, cnt_clr) built when
// LANE_SHIFTER_STATS_EN is defined.
module lane_shifter_pipe
  import lane_shift_pkg::*;
#(
  parameter int unsigned LANE_W    = 12,
  parameter int unsigned LANES     = 8,
  parameter int unsigned MAX_SHIFT = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*LANE_W-1:0]    in_data,
  input  logic [shift_w(LANES)-1:0]  in_shift,
  input  logic [1:0]                 in_mode,
  input  logic [LANE_W-1:0]          in_fill,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*LANE_W-1:0]    out_data,
  output logic                       out_err
`ifdef LANE_SHIFTER_STATS_EN
  ,
  input  logic                       cnt_clr,
  output logic [ERR_CNT_W-1:0]       err_cnt
`endif
);

  logic [LANES*LANE_W-1:0] core_data;
  logic                    core_err;

  logic                    s1_valid;
  logic [LANES*LANE_W-1:0] s1_data;
  logic                    s1_err;
  logic                    s2_valid;
  logic [LANES*LANE_W-1:0] s2_data;
  logic                    s2_err;

  logic                    s1_adv;
  logic                    in_fire;

  lane_shift_core #(
    .LANE_W    (LANE_W),
    .LANES     (LANES),
    .MAX_SHIFT (MAX_SHIFT)
  ) u_core (
    .data   (in_data),
    .shift  (in_shift),
    .mode   (in_mode),
    .fill   (in_fill),
    .result (core_data),
    .err    (core_err)
  );

  assign s1_adv   = s1_valid && (!s2_valid || out_ready);
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // S1: capture the shifter result on each input transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_err   <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= core_data;
      s1_err   <= core_err;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: output register, loads from S1 and empties on an output transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_err   <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= s1_data;
      s2_err   <= s1_err;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_err   = s2_err;

`ifdef LANE_SHIFTER_STATS_EN
  // Saturating count of erroneous words leaving the block; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (cnt_clr) begin
      err_cnt <= '0;
    end else if (s2_valid && out_ready && s2_err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lane_shifter_pipe.sv
// Directed self-checking bench for lane_shifter_pipe (default parameters).
module tb_lane_shifter_pipe;
  import lane_shift_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [2:0]  in_shift;
  logic [1:0]  in_mode;
  logic [11:0] in_fill;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic        out_err;
`ifdef LANE_SHIFTER_STATS_EN
  logic        cnt_clr;
  logic [15:0] err_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  lane_shifter_pipe #(
    .LANE_W    (12),
    .LANES     (8),
    .MAX_SHIFT (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_mode   (in_mode),
    .in_fill   (in_fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef LANE_SHIFTER_STATS_EN
    ,
    .cnt_clr   (cnt_clr),
    .err_cnt   (err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  shift;
    logic [1:0]  mode;
    logic [11:0] fill;
    logic [95:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam logic [95:0] BASE = 96'h0AB_789_678_567_456_345_234_123;

  vec_t vecs [11];

  function automatic logic [95:0] word_of(input int idx);
    logic [95:0] w;
    for (int k = 0; k < 8; k++) w[k*12 +: 12] = 12'(idx * 16 + k + 1);
    return w;
  endfunction

`ifdef LANE_SHIFTER_STATS_EN
  task automatic stream_illegal(input int n);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = BASE;
    in_shift  = 3'd7;
    in_mode   = ROTL;
    in_fill   = 12'h111;
    repeat (n) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    vecs[0]  = '{3'd1, SHL_FILL, 12'hFFF, 96'h789_678_567_456_345_234_123_FFF, 1'b0};
    vecs[1]  = '{3'd3, SHR_FILL, 12'hEEE, 96'hEEE_EEE_EEE_0AB_789_678_567_456, 1'b0};
    vecs[2]  = '{3'd3, ROTL,     12'h000, 96'h567_456_345_234_123_0AB_789_678, 1'b0};
    vecs[3]  = '{3'd5, ROTR,     12'h000, 96'h567_456_345_234_123_0AB_789_678, 1'b0};
    vecs[4]  = '{3'd6, ROTL,     12'h5A5, {8{12'h5A5}},                         1'b1};
    vecs[5]  = '{3'd0, SHL_FILL, 12'h5A5, BASE,                                 1'b0};
    vecs[6]  = '{3'd5, SHL_FILL, 12'h000, 96'h345_234_123_000_000_000_000_000, 1'b0};
    vecs[7]  = '{3'd7, SHR_FILL, 12'h0C3, {8{12'h0C3}},                         1'b1};
    vecs[8]  = '{3'd0, ROTR,     12'h777, BASE,                                 1'b0};
    vecs[9]  = '{3'd1, ROTL,     12'h777, 96'h789_678_567_456_345_234_123_0AB, 1'b0};
    vecs[10] = '{3'd5, SHR_FILL, 12'hABC, 96'hABC_ABC_ABC_ABC_ABC_0AB_789_678, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_mode   = '0;
    in_fill   = '0;
    out_ready = 1'b0;
`ifdef LANE_SHIFTER_STATS_EN
    cnt_clr   = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_out_err",   out_err,   0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Single-word vectors, latency check on each
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = BASE;
      in_shift = vecs[i].shift;
      in_mode  = vecs[i].mode;
      in_fill  = vecs[i].fill;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = ~BASE;
      #1;
      chk($sformatf("v%0d_lat_early", i), out_valid, 0);
      @(negedge clk);
      chk($sformatf("v%0d_out_valid", i), out_valid, 1);
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("v%0d_out_err", i), out_err, vecs[i].exp_err);
    end
    @(negedge clk);

    // Back-to-back stream with out_ready pattern 0/1/1/0
    begin
      int sent = 0;
      int got  = 0;
      int occ  = 0;
      logic held = 1'b0;
      logic [95:0] held_data = '0;
      logic [95:0] exp_q [$];
      for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
        @(negedge clk);
        out_ready = ((cyc % 4) == 1) || ((cyc % 4) == 2);
        if (sent < 10) begin
          in_valid = 1'b1;
          in_data  = word_of(sent);
          in_shift = 3'd0;
          in_mode  = 2'(sent % 4);
          in_fill  = 12'hFFF;
        end else begin
          in_valid = 1'b0;
        end
        #1;
        if (held) chk("bp_hold_data", out_data, held_data);
        chk("bp_in_ready", in_ready, !(occ == 2 && !out_ready));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("bp_unexpected_out", 1, 0);
          end else begin
            chk("bp_order_data", out_data, exp_q.pop_front());
            chk("bp_out_err", out_err, 0);
          end
          got++;
          occ--;
        end
        held      = out_valid && !out_ready;
        held_data = out_data;
        if (in_valid && in_ready) begin
          exp_q.push_back(in_data);
          sent++;
          occ++;
        end
      end
      chk("bp_word_count", 96'(got), 96'd10);
    end

    // Reset with both stages full
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = BASE;
    in_shift = 3'd2;
    in_mode  = ROTL;
    @(negedge clk);
    in_data  = word_of(3);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mid_full_in_ready", in_ready, 0);
    chk("mid_full_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_err", out_err, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("mid_rel_in_ready", in_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("mid_no_stale", out_valid, 0);
    end

`ifdef LANE_SHIFTER_STATS_EN
    chk("cnt_after_reset", 96'(err_cnt), 0);
    stream_illegal(3);
    chk("cnt_three", 96'(err_cnt), 3);
    @(negedge clk);
    in_valid = 1'b1;
    in_shift = 3'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("cnt_4th_valid", out_valid, 1);
    chk("cnt_4th_err", out_err, 1);
    cnt_clr = 1'b1;
    #1;
    chk("cnt_before_clr", 96'(err_cnt), 3);
    @(negedge clk);
    cnt_clr = 1'b0;
    #1;
    chk("cnt_cleared", 96'(err_cnt), 0);
    stream_illegal(65535);
    chk("cnt_reach_max", 96'(err_cnt), 96'hFFFF);
    stream_illegal(2);
    chk("cnt_saturated", 96'(err_cnt), 96'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
